// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the serial adder.
// The requester drives start and the operands; the adder returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, with the carry registered between digits. A new operation is
// accepted from IDLE or directly from DONE (back-to-back). The published
// result only changes on a completion edge or on reset.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParams
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_capture;
  logic             w_busy;
  logic             w_done;
  logic             w_lastDigit;
  logic [DIGIT:0]   w_digitSum;
  logic             w_digitCout;
  logic             w_msbCarryIn;
  logic [WIDTH-1:0] w_resNext;

  assign w_lastDigit = (r_cnt == CW'(N - 1));

  // Digit adder: low DIGIT bits of both shift registers plus the registered carry
  always_comb begin
    w_digitSum   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};
    w_digitCout  = w_digitSum[DIGIT];
    // Carry into the digit's top bit recovered from its operand and sum bits;
    // on the final digit this is the carry into bit WIDTH-1.
    w_msbCarryIn = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_digitSum[DIGIT-1];
    // New digit enters the result register from the top
    w_resNext    = (r_res >> DIGIT)
                 | (WIDTH'(w_digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode, capture strobe and status outputs
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_capture   = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_capture   = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture, digit-serial shifting and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_capture) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_resNext;
      r_carry <= w_digitCout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_lastDigit) begin
        r_sum  <= w_resNext;
        r_cout <= w_digitCout;
        r_ovf  <= w_msbCarryIn ^ w_digitCout;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder across several WIDTH/DIGIT
// configurations, compared against a plain-arithmetic reference model.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Configurations: 0=8/1, 1=1/1, 2=16/4, 3=8/2, 4=8/8
  serial_adder_if #(.WIDTH(8))  if0 ();
  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(16)) if2 ();
  serial_adder_if #(.WIDTH(8))  if3 ();
  serial_adder_if #(.WIDTH(8))  if4 ();

  serial_adder #(.WIDTH(8),  .DIGIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  serial_adder #(.WIDTH(1),  .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_adder #(.WIDTH(16), .DIGIT(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  serial_adder #(.WIDTH(8),  .DIGIT(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  serial_adder #(.WIDTH(8),  .DIGIT(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int          checks = 0;
  int          errors = 0;
  int          cfgW [5] = '{8, 1, 16, 8, 8};
  int          cfgD [5] = '{1, 1, 4, 2, 8};
  logic [15:0] lastSum [5];
  int          opCount [5];
  int          doneCount [5];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int cfg, input logic st, input logic [15:0] a,
                               input logic [15:0] b, input logic c);
    case (cfg)
      0: begin if0.start = st; if0.a = a[7:0]; if0.b = b[7:0]; if0.cin = c; end
      1: begin if1.start = st; if1.a = a[0];   if1.b = b[0];   if1.cin = c; end
      2: begin if2.start = st; if2.a = a;      if2.b = b;      if2.cin = c; end
      3: begin if3.start = st; if3.a = a[7:0]; if3.b = b[7:0]; if3.cin = c; end
      4: begin if4.start = st; if4.a = a[7:0]; if4.b = b[7:0]; if4.cin = c; end
      default: ;
    endcase
  endtask

  task automatic readOutputs(input int cfg, output logic bsy, output logic dn,
                             output logic [15:0] s, output logic co, output logic ov);
    bsy = 1'b0; dn = 1'b0; s = '0; co = 1'b0; ov = 1'b0;
    case (cfg)
      0: begin bsy = if0.busy; dn = if0.done; s = 16'(if0.sum); co = if0.cout; ov = if0.overflow; end
      1: begin bsy = if1.busy; dn = if1.done; s = 16'(if1.sum); co = if1.cout; ov = if1.overflow; end
      2: begin bsy = if2.busy; dn = if2.done; s = if2.sum;      co = if2.cout; ov = if2.overflow; end
      3: begin bsy = if3.busy; dn = if3.done; s = 16'(if3.sum); co = if3.cout; ov = if3.overflow; end
      4: begin bsy = if4.busy; dn = if4.done; s = 16'(if4.sum); co = if4.cout; ov = if4.overflow; end
      default: ;
    endcase
  endtask

  // Reference: full-width integer addition; signed overflow when both
  // operands share a sign and the sum's sign differs.
  task automatic refAdd(input int cfg, input logic [15:0] a, input logic [15:0] b,
                        input logic c, output logic [15:0] s, output logic co, output logic ov);
    int          w;
    logic [16:0] mask;
    logic [16:0] full;
    w    = cfgW[cfg];
    mask = (17'd1 << w) - 17'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(c);
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endtask

  // One operation: starts at a negedge, ends at the negedge where done is
  // seen. Operands are scrambled during RUN and start is toggled randomly
  // (or held high) to show neither disturbs the result.
  task automatic doOp(input int cfg, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input bit holdStart, input bit onesDuringRun);
    logic        bsy, dn, co, ov, expC, expO, st;
    logic [15:0] s, expS, junkA, junkB;
    int          n, busyCycles, lat, id;
    bit          seen;
    n  = cfgW[cfg] / cfgD[cfg];
    id = opCount[cfg];
    refAdd(cfg, a, b, c, expS, expC, expO);
    applyStimulus(cfg, 1'b1, a, b, c);
    @(posedge clk);
    busyCycles = 0;
    seen       = 1'b0;
    lat        = -1;
    for (int j = 0; j <= n + 4 && !seen; j++) begin
      @(negedge clk);
      readOutputs(cfg, bsy, dn, s, co, ov);
      checkOutput($sformatf("cfg%0d op%0d busy/done exclusive", cfg, id), 32'(bsy & dn), 32'd0);
      if (j == 0) begin
        checkOutput($sformatf("cfg%0d op%0d done low after capture", cfg, id), 32'(dn), 32'd0);
        checkOutput($sformatf("cfg%0d op%0d sum held during run", cfg, id), 32'(s), 32'(lastSum[cfg]));
      end
      if (bsy) busyCycles++;
      junkA = onesDuringRun ? 16'hFFFF : 16'($urandom);
      junkB = onesDuringRun ? 16'hFFFF : 16'($urandom);
      if (dn) begin
        seen = 1'b1;
        lat  = j;
        applyStimulus(cfg, holdStart, junkA, junkB, 1'($urandom));
      end else begin
        st = holdStart ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        applyStimulus(cfg, st, junkA, junkB, 1'($urandom));
      end
    end
    checkOutput($sformatf("cfg%0d op%0d done latency", cfg, id), 32'(lat), 32'(n));
    checkOutput($sformatf("cfg%0d op%0d busy cycles", cfg, id), 32'(busyCycles), 32'(n));
    if (seen) begin
      checkOutput($sformatf("cfg%0d op%0d sum", cfg, id), 32'(s), 32'(expS));
      checkOutput($sformatf("cfg%0d op%0d cout", cfg, id), 32'(co), 32'(expC));
      checkOutput($sformatf("cfg%0d op%0d overflow", cfg, id), 32'(ov), 32'(expO));
      doneCount[cfg]++;
    end
    lastSum[cfg] = expS;
    opCount[cfg]++;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed and randomised sequence
  initial begin
    logic        bsy, dn, co, ov;
    logic [15:0] s;
    logic [2:0]  v;
    int          spuriousDone;
    int          randCfg [4] = '{0, 3, 4, 2};

    for (int c = 0; c < 5; c++) begin
      lastSum[c]   = '0;
      opCount[c]   = 0;
      doneCount[c] = 0;
      applyStimulus(c, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    readOutputs(0, bsy, dn, s, co, ov);
    checkOutput("reset busy", 32'(bsy), 32'd0);
    checkOutput("reset done", 32'(dn), 32'd0);
    checkOutput("reset sum", 32'(s), 32'd0);
    checkOutput("reset cout", 32'(co), 32'd0);
    checkOutput("reset overflow", 32'(ov), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and carry/overflow corner cases, 8-bit digit-serial
    doOp(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    doOp(0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0);
    doOp(0, 16'h80, 16'h80, 1'b0, 1'b0, 1'b0);
    doOp(0, 16'hFF, 16'h00, 1'b1, 1'b0, 1'b0);

    // Full-adder truth table with WIDTH=1
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      doOp(1, 16'(v[2]), 16'(v[1]), v[0], 1'b0, 1'b0);
      @(negedge clk);
    end

    // 16/4 with start held high for back-to-back operation
    doOp(2, 16'h1234, 16'hEDCC, 1'b0, 1'b1, 1'b0);
    doOp(2, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    doOp(2, 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);

    // Operands driven to all-ones during RUN must not matter
    @(negedge clk);
    doOp(0, 16'h10, 16'h20, 1'b0, 1'b0, 1'b1);

    // Reset in the third RUN cycle of the next operation
    @(negedge clk);
    applyStimulus(0, 1'b1, 16'h55, 16'h66, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 1'b0, 16'h55, 16'h66, 1'b0);
    repeat (2) @(negedge clk);
    readOutputs(0, bsy, dn, s, co, ov);
    checkOutput("pre-reset sum held", 32'(s), 32'h30);
    checkOutput("pre-reset busy", 32'(bsy), 32'd1);
    rst_n = 1'b0;
    #1;
    readOutputs(0, bsy, dn, s, co, ov);
    checkOutput("mid-run reset busy", 32'(bsy), 32'd0);
    checkOutput("mid-run reset done", 32'(dn), 32'd0);
    checkOutput("mid-run reset sum", 32'(s), 32'd0);
    checkOutput("mid-run reset cout", 32'(co), 32'd0);
    checkOutput("mid-run reset overflow", 32'(ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) lastSum[c] = '0;
    spuriousDone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      readOutputs(0, bsy, dn, s, co, ov);
      if (dn || bsy) spuriousDone++;
    end
    checkOutput("no activity after mid-run reset", 32'(spuriousDone), 32'd0);
    doOp(0, 16'h77, 16'h11, 1'b1, 1'b0, 1'b0);

    // Randomised operations per configuration
    foreach (randCfg[k]) begin
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        doOp(randCfg[k], 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
    end

    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("cfg%0d done count", c), 32'(doneCount[c]), 32'(opCount[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
